ppu_frame_writer: RTL and testbench

- Sits directly downstream of the PPU pixel pipeline.
- Consumes the PPU's per-pixel strobe (X, Y, 2-bit colour index, write enable), applies the BGP palette, computes the linear framebuffer address and buffers the result in a small FIFO.
- Drains the FIFO into the 160x144 framebuffer RAM over a valid/ready write port.
- Flags frame completion and overflow to the display/control logic.

---
 rtl/ppu_frame_writer.sv | 117 +++++++++++
 tb/tb_ppu_frame_writer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppu_frame_writer.sv
// Buffers palette-mapped PPU pixel writes in a show-ahead FIFO and drains them
// into the 160x144 framebuffer over a valid/ready port; flags frame end and drops.
module ppu_frame_writer #(
  parameter int FIFO_DEPTH = 8,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 144
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    pix_x,
  input  logic [7:0]                    pix_y,
  input  logic [1:0]                    pix_val,
  input  logic                          pix_wren,
  input  logic [7:0]                    bgp,
  input  logic                          overflow_clr,
  output logic [14:0]                   fb_addr,
  output logic [1:0]                    fb_data,
  output logic                          fb_wren,
  input  logic                          fb_ready,
  output logic                          frame_done,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);
  localparam logic [7:0]    X_LIMIT    = 8'(SCREEN_W);
  localparam logic [7:0]    Y_LIMIT    = 8'(SCREEN_H);
  localparam logic [14:0]   LAST_ADDR  = 15'(SCREEN_W * SCREEN_H - 1);

  typedef enum logic {IDLE, REQ} state_t;

  // Linear address y*160 + x built from shifts so it maps to two adders.
  function automatic logic [14:0] pixel_addr(input logic [7:0] x, input logic [7:0] y);
    logic [14:0] y15;
    y15 = {7'd0, y};
    return (y15 << 7) + (y15 << 5) + {7'd0, x};
  endfunction

  function automatic logic [1:0] palette_shade(input logic [7:0] pal, input logic [1:0] idx);
    return pal[{idx, 1'b0} +: 2];
  endfunction

  state_t         state, state_next;
  logic [PW-1:0]  wr_ptr, rd_ptr;
  logic [LW-1:0]  level, level_next;
  logic [14:0]    addr_mem  [FIFO_DEPTH];
  logic [1:0]     shade_mem [FIFO_DEPTH];

  logic           in_range_p0, full, push, pop, drop;
  logic [14:0]    addr_p0;
  logic [1:0]     shade_p0;

  // ---- stage p0: qualify strobe, map palette, form address ----
  assign in_range_p0 = pix_wren && (pix_x < X_LIMIT) && (pix_y < Y_LIMIT);
  assign addr_p0     = pixel_addr(pix_x, pix_y);
  assign shade_p0    = palette_shade(bgp, pix_val);

  assign full = (level == FULL_LEVEL);
  assign pop  = (state == REQ) && fb_ready;
  assign push = in_range_p0 && (!full || pop);
  assign drop = in_range_p0 && full && !pop;

  always_comb begin
    level_next = level;
    case ({push, pop})
      2'b10:   level_next = level + LW'(1);
      2'b01:   level_next = level - LW'(1);
      default: level_next = level;
    endcase
  end

  // ---- FIFO storage: data only, never reset ----
  always_ff @(posedge clock) begin
    if (push) begin
      addr_mem[wr_ptr]  <= addr_p0;
      shade_mem[wr_ptr] <= shade_p0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
      state      <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      level      <= level_next;
      state      <= state_next;
      frame_done <= pop && (addr_mem[rd_ptr] == LAST_ADDR);
      // A drop in the same cycle as a clear keeps the flag set.
      if (drop)              overflow <= 1'b1;
      else if (overflow_clr) overflow <= 1'b0;
    end
  end

  // ---- drain FSM: head entry is presented while in REQ ----
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (level != '0) state_next = REQ;
      REQ:     if (pop && (level_next == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign fb_wren    = (state == REQ);
  assign fb_addr    = fb_wren ? addr_mem[rd_ptr]  : '0;
  assign fb_data    = fb_wren ? shade_mem[rd_ptr] : '0;
  assign fifo_level = level;

endmodule

// File: tb/tb_ppu_frame_writer.sv
// Bench for ppu_frame_writer: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_ppu_frame_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic [7:0]  d_x, d_y, d_bgp;
  logic [1:0]  d_val;
  logic        d_wren, d_ready, d_clr;
  logic [14:0] fb_addr;
  logic [1:0]  fb_data;
  logic        fb_wren, frame_done, overflow;
  logic [3:0]  fifo_level;

  always #5 clock = ~clock;

  ppu_frame_writer #(.FIFO_DEPTH(8), .SCREEN_W(160), .SCREEN_H(144)) dut (
    .clock(clock), .reset(reset),
    .pix_x(d_x), .pix_y(d_y), .pix_val(d_val), .pix_wren(d_wren),
    .bgp(d_bgp), .overflow_clr(d_clr),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_wren(fb_wren), .fb_ready(d_ready),
    .frame_done(frame_done), .overflow(overflow), .fifo_level(fifo_level)
  );

  typedef struct { int addr; int shade; } ent_t;
  typedef struct {
    logic [7:0] x; logic [7:0] y; logic [1:0] val; logic [7:0] bgp;
    int addr; int shade;
  } vec_t;

  ent_t q[$];
  bit   m_wren, m_ovf, m_done;
  int   checks = 0, failures = 0;
  bit   seq_en = 0;
  int   seq_n = 0;
  vec_t vt[7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_wren = 0; m_ovf = 0; m_done = 0;
  endtask

  task automatic drive(input int x, input int y, input int val, input bit wren,
                       input int bgp, input bit ready);
    d_x = 8'(x); d_y = 8'(y); d_val = 2'(val); d_wren = wren;
    d_bgp = 8'(bgp); d_ready = ready;
  endtask

  // Compare DUT against model for the current cycle, then advance both by one edge.
  task automatic cycle();
    int   sz;
    bit   pop, acc;
    ent_t h, e;
    chk("fb_wren", fb_wren, m_wren);
    if (m_wren) begin
      chk("fb_addr", fb_addr, q[0].addr);
      chk("fb_data", fb_data, q[0].shade);
    end
    chk("fifo_level", fifo_level, q.size());
    chk("overflow", overflow, m_ovf);
    chk("frame_done", frame_done, m_done);

    sz  = q.size();
    pop = m_wren && d_ready;
    acc = d_wren && (d_x < 160) && (d_y < 144);
    if (pop && seq_en) begin
      chk("seq_addr", fb_addr, seq_n);
      chk("seq_data", fb_data, 3 - (seq_n % 4));
      seq_n++;
    end
    m_done = 0;
    if (pop) begin
      h = q.pop_front();
      m_done = (h.addr == 23039);
    end
    if (acc && sz == 8 && !pop) m_ovf = 1;
    else begin
      if (acc) begin
        e.addr  = int'(d_y) * 160 + int'(d_x);
        e.shade = (int'(d_bgp) >> (2 * int'(d_val))) & 3;
        q.push_back(e);
      end
      if (d_clr) m_ovf = 0;
    end
    m_wren = m_wren ? (q.size() > 0) : (sz > 0);
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((q.size() > 0 || m_wren) && n < budget) begin
      cycle();
      n++;
    end
    chk("drain_bound", n < budget, 1);
  endtask

  initial begin
    vt[0] = '{8'd5,   8'd2,   2'd3, 8'hE4, 325,   3};
    vt[1] = '{8'd0,   8'd0,   2'd0, 8'hE4, 0,     0};
    vt[2] = '{8'd159, 8'd0,   2'd1, 8'hE4, 159,   1};
    vt[3] = '{8'd0,   8'd1,   2'd2, 8'hE4, 160,   2};
    vt[4] = '{8'd10,  8'd100, 2'd2, 8'h1B, 16010, 1};
    vt[5] = '{8'd77,  8'd50,  2'd1, 8'h9C, 8077,  3};
    vt[6] = '{8'd159, 8'd143, 2'd0, 8'h1B, 23039, 3};

    reset = 1'b1; d_clr = 0;
    drive(0, 0, 0, 0, 0, 1);
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    chk("rst_wren", fb_wren, 0);
    chk("rst_addr", fb_addr, 0);
    chk("rst_data", fb_data, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_level", fifo_level, 0);
    @(negedge clock);
    reset = 1'b0;
    cycle();

    // Single-strobe vectors: push, present one edge later, pop, idle.
    for (int i = 0; i < 7; i++) begin
      drive(vt[i].x, vt[i].y, vt[i].val, 1, vt[i].bgp, 1);
      cycle();
      chk("vec_level1", fifo_level, 1);
      drive(0, 0, 0, 0, 8'hFF, 1);
      cycle();
      chk("vec_wren", fb_wren, 1);
      chk("vec_addr", fb_addr, vt[i].addr);
      chk("vec_data", fb_data, vt[i].shade);
      cycle();
      chk("vec_idle", fb_wren, 0);
      chk("vec_level0", fifo_level, 0);
      cycle();
    end

    // Full line 0 at one pixel per cycle.
    seq_en = 1; seq_n = 0;
    for (int i = 0; i < 160; i++) begin
      drive(i, 0, i % 4, 1, 8'h1B, 1);
      cycle();
    end
    drive(0, 0, 0, 0, 8'h1B, 1);
    drain(20);
    seq_en = 0;
    chk("line_count", seq_n, 160);
    chk("line_ovf", overflow, 0);

    // Stalled port: overfill by two.
    for (int i = 0; i < 10; i++) begin
      drive(20 + i, 3, i % 4, 1, 8'hE4, 0);
      cycle();
    end
    chk("stall_level", fifo_level, 8);
    chk("stall_ovf", overflow, 1);
    chk("stall_addr", fb_addr, 500);
    begin
      int writes;
      writes = 0;
      drive(0, 0, 0, 0, 8'hE4, 1);
      for (int i = 0; i < 30; i++) begin
        if (fb_wren && d_ready) writes++;
        cycle();
      end
      chk("stall_writes", writes, 8);
      chk("stall_idle", fb_wren, 0);
    end
    chk("ovf_sticky", overflow, 1);
    d_clr = 1;
    cycle();
    d_clr = 0;
    chk("ovf_clr", overflow, 0);

    // Off-screen strobes are ignored.
    drive(5, 144, 1, 1, 8'hE4, 1);   cycle();
    drive(160, 0, 1, 1, 8'hE4, 1);   cycle();
    drive(255, 255, 1, 1, 8'hE4, 1); cycle();
    drive(0, 153, 1, 1, 8'hE4, 1);   cycle();
    drive(0, 0, 0, 0, 8'hE4, 1);     cycle();
    chk("oob_level", fifo_level, 0);
    chk("oob_ovf", overflow, 0);

    // Full FIFO with simultaneous push and pop, then the last pixel of a frame.
    for (int i = 0; i < 8; i++) begin
      drive(i, 10, i % 4, 1, 8'hE4, 0);
      cycle();
    end
    chk("full_level", fifo_level, 8);
    drive(100, 10, 2, 1, 8'hE4, 1);
    cycle();
    chk("pp_level", fifo_level, 8);
    chk("pp_ovf", overflow, 0);
    drive(159, 143, 3, 1, 8'hE4, 1);
    cycle();
    chk("pp_level2", fifo_level, 8);
    begin
      int pulses;
      pulses = 0;
      drive(0, 0, 0, 0, 8'hE4, 1);
      for (int i = 0; i < 30; i++) begin
        if (frame_done) pulses++;
        cycle();
      end
      chk("done_pulses", pulses, 1);
    end

    // Asynchronous reset in the middle of a stalled drain.
    for (int i = 0; i < 4; i++) begin
      drive(30 + i, 7, 1, 1, 8'hE4, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 8'hE4, 0);
    cycle();
    chk("pre_rst_wren", fb_wren, 1);
    chk("pre_rst_level", fifo_level, 4);
    #2 reset = 1'b1;
    #1;
    chk("arst_wren", fb_wren, 0);
    chk("arst_addr", fb_addr, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_ovf", overflow, 0);
    model_reset();
    #2 reset = 1'b0;
    d_ready = 1;
    for (int i = 0; i < 6; i++) cycle();
    chk("post_rst_level", fifo_level, 0);

    // Randomized traffic with bursty back-pressure.
    begin
      int mode;
      mode = 0;
      for (int i = 0; i < 3000; i++) begin
        if (i % 50 == 0) mode = $urandom_range(0, 2);
        d_wren  = ($urandom_range(0, 9) < 7);
        d_x     = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
        d_y     = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(144, 255)) : 8'($urandom_range(0, 143));
        if ($urandom_range(0, 19) == 0) begin d_x = 8'd159; d_y = 8'd143; end
        d_val   = 2'($urandom_range(0, 3));
        d_bgp   = 8'($urandom_range(0, 255));
        d_clr   = ($urandom_range(0, 19) == 0);
        d_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 7) == 0);
        cycle();
      end
      d_wren = 0; d_clr = 0; d_ready = 1;
      drain(40);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
